// File: rtl/seq_pkg.sv
// Shared definitions for the Y86-64 sequential controller: status codes,
// controller states and stage-enable bit positions.
package seq_pkg;

    // Architectural status register encodings
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // One-hot stage enable bit positions
    localparam int STAGE_W   = 6;
    localparam int EN_FETCH  = 0;
    localparam int EN_DECODE = 1;
    localparam int EN_EXEC   = 2;
    localparam int EN_MEM    = 3;
    localparam int EN_WB     = 4;
    localparam int EN_PCUPD  = 5;

    // Controller states; the six stage states are contiguous
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_PCUPD  = 4'd6,
        S_PAUSE  = 4'd7,
        S_STOP   = 4'd8
    } state_t;

endpackage

// File: rtl/seq_perf_cnt.sv
// Cycle and retired-instruction counters. Both wrap modulo 2^CNT_W and are
// cleared by reset or by the clear input (start of a new run).
module seq_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_cyc_inc,
    input  logic             i_ret_inc,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_retired
);

    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_retired;

    // Count stage cycles and retirements; clear has priority over increment
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cycle_cnt <= '0;
            r_retired   <= '0;
        end else begin
            if (i_cyc_inc) r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (i_ret_inc) r_retired   <= r_retired + 1'b1;
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
    assign o_retired   = r_retired;

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle sequencer for the Y86-64 sequential datapath. Owns PC and
// status, walks one stage per clock, stops on halt or exception, and
// supports single-step via PAUSE. Current state is exported on dbg_state.
module seq_controller
    import seq_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step_req,
    input  logic [63:0]        new_pc,
    input  logic               hlt,
    input  logic               in_mem,
    input  logic               in_inst,
    input  logic               dmem_err,
    output logic [63:0]        pc,
    output logic [5:0]         stage_en,
    output logic [2:0]         status,
    output logic               running,
    output logic               step_ack,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   retired,
    output state_t             dbg_state
);

    state_t               r_state;
    logic   [63:0]        r_pc;
    logic   [2:0]         r_status;
    logic                 r_step_ack;

    state_t               w_next_state;
    logic   [63:0]        w_pc_next;
    logic   [2:0]         w_status_next;
    logic                 w_step_ack_next;
    logic                 w_clear;
    logic                 w_ret_inc;
    logic   [STAGE_W-1:0] w_stage_en;
    logic                 w_running;

    // State, PC, status and step_ack registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_status   <= STAT_AOK;
            r_step_ack <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_pc_next;
            r_status   <= w_status_next;
            r_step_ack <= w_step_ack_next;
        end
    end

    // Next-state, PC/status updates and counter controls
    always_comb begin
        w_next_state    = r_state;
        w_pc_next       = r_pc;
        w_status_next   = r_status;
        w_step_ack_next = 1'b0;
        w_clear         = 1'b0;
        w_ret_inc       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state  = S_FETCH;
                    w_pc_next     = RESET_PC;
                    w_status_next = STAT_AOK;
                    w_clear       = 1'b1;
                end
            end
            S_FETCH: begin
                // Fetch faults: bad address beats bad opcode beats halt
                if (in_mem) begin
                    w_status_next = STAT_ADR;
                    w_next_state  = S_STOP;
                end else if (in_inst) begin
                    w_status_next = STAT_INS;
                    w_next_state  = S_STOP;
                end else if (hlt) begin
                    w_status_next = STAT_HLT;
                    w_next_state  = S_STOP;
                end else begin
                    w_next_state  = S_DECODE;
                end
            end
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC:   w_next_state = S_MEM;
            S_MEM: begin
                // A data-memory fault stops before writeback and PC update
                if (dmem_err) begin
                    w_status_next = STAT_ADR;
                    w_next_state  = S_STOP;
                end else begin
                    w_next_state  = S_WB;
                end
            end
            S_WB: w_next_state = S_PCUPD;
            S_PCUPD: begin
                w_pc_next = new_pc;
                w_ret_inc = 1'b1;
                if (step_mode) begin
                    w_next_state    = S_PAUSE;
                    w_step_ack_next = 1'b1;
                end else begin
                    w_next_state    = S_FETCH;
                end
            end
            S_PAUSE: begin
                if (step_req || !step_mode) w_next_state = S_FETCH;
            end
            S_STOP: w_next_state = S_STOP;
            default: w_next_state = S_IDLE;
        endcase
    end

    // One-hot stage enable decoded from the current state
    always_comb begin
        w_stage_en = '0;
        case (r_state)
            S_FETCH:  w_stage_en[EN_FETCH]  = 1'b1;
            S_DECODE: w_stage_en[EN_DECODE] = 1'b1;
            S_EXEC:   w_stage_en[EN_EXEC]   = 1'b1;
            S_MEM:    w_stage_en[EN_MEM]    = 1'b1;
            S_WB:     w_stage_en[EN_WB]     = 1'b1;
            S_PCUPD:  w_stage_en[EN_PCUPD]  = 1'b1;
            default:  w_stage_en = '0;
        endcase
    end

    assign w_running = |w_stage_en;

    seq_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_cyc_inc   (w_running),
        .i_ret_inc   (w_ret_inc),
        .o_cycle_cnt (cycle_cnt),
        .o_retired   (retired)
    );

    assign pc        = r_pc;
    assign status    = r_status;
    assign stage_en  = w_stage_en;
    assign running   = w_running;
    assign step_ack  = r_step_ack;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller: directed instruction sequences,
// with expected PC / retired values queued at PCUPD and checked afterwards.
module tb_seq_controller;
    import seq_pkg::*;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam int          CW     = 32;

    logic          clk = 1'b0;
    logic          rst, start, step_mode, step_req;
    logic [63:0]   new_pc;
    logic          hlt, in_mem, in_inst, dmem_err;
    logic [63:0]   pc;
    logic [5:0]    stage_en;
    logic [2:0]    status;
    logic          running, step_ack;
    logic [CW-1:0] cycle_cnt, retired;
    state_t        dbg_state;

    logic [63:0] exp_q[$];
    logic [63:0] ret_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          m_ret = 0;
    logic [5:0]  seen_en;

    seq_controller #(
        .RESET_PC (RST_PC),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .step_mode (step_mode),
        .step_req  (step_req),
        .new_pc    (new_pc),
        .hlt       (hlt),
        .in_mem    (in_mem),
        .in_inst   (in_inst),
        .dmem_err  (dmem_err),
        .pc        (pc),
        .stage_en  (stage_en),
        .status    (status),
        .running   (running),
        .step_ack  (step_ack),
        .cycle_cnt (cycle_cnt),
        .retired   (retired),
        .dbg_state (dbg_state)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        new_pc = '0; hlt = 1'b0; in_mem = 1'b0; in_inst = 1'b0; dmem_err = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        m_ret = 0;
        exp_q.delete();
        ret_q.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_ret = 0;
    endtask

    // Called in a FETCH cycle; walks six stages and checks the retirement
    task automatic run_instr(input logic [63:0] npc);
        for (int s = 0; s < 6; s++) begin
            check_val($sformatf("stage_en_%0d", s), {58'd0, stage_en}, 64'd1 << s);
            new_pc = npc;
            if (s == 5) begin
                m_ret++;
                exp_q.push_back(npc);
                ret_q.push_back(64'(m_ret));
            end
            tick();
        end
        if (exp_q.size() == 0 || ret_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: expected queue empty");
        end else begin
            check_val("pc_after_pcupd", pc, exp_q.pop_front());
            check_val("retired_after_pcupd", {32'd0, retired}, ret_q.pop_front());
        end
    endtask

    task automatic fetch_fault(input logic f_mem, input logic f_inst, input logic f_hlt,
                               input logic [2:0] exp_stat, input string tag);
        do_reset();
        do_start();
        check_val({tag, "_in_fetch"}, {58'd0, stage_en}, 64'd1);
        in_mem = f_mem; in_inst = f_inst; hlt = f_hlt;
        tick();
        in_mem = 1'b0; in_inst = 1'b0; hlt = 1'b0;
        check_val({tag, "_status"}, {61'd0, status}, {61'd0, exp_stat});
        check_val({tag, "_running"}, {63'd0, running}, 64'd0);
        check_val({tag, "_retired"}, {32'd0, retired}, 64'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        check_val("rst_pc", pc, RST_PC);
        check_val("rst_status", {61'd0, status}, {61'd0, STAT_AOK});
        check_val("rst_stage_en", {58'd0, stage_en}, 64'd0);
        check_val("rst_running", {63'd0, running}, 64'd0);
        check_val("rst_step_ack", {63'd0, step_ack}, 64'd0);
        check_val("rst_cycle_cnt", {32'd0, cycle_cnt}, 64'd0);
        check_val("rst_retired", {32'd0, retired}, 64'd0);

        // Idle ignores stray fault inputs
        hlt = 1'b1; in_mem = 1'b1;
        tick();
        hlt = 1'b0; in_mem = 1'b0;
        check_val("idle_ignore_status", {61'd0, status}, {61'd0, STAT_AOK});

        // Four normal instructions
        do_start();
        check_val("start_pc", pc, RST_PC);
        run_instr(64'd10);
        run_instr(64'd20);
        run_instr(64'd30);
        run_instr(64'd40);
        check_val("four_pc", pc, 64'd40);
        check_val("four_retired", {32'd0, retired}, 64'd4);
        check_val("four_cycles", {32'd0, cycle_cnt}, 64'd24);
        check_val("four_status", {61'd0, status}, {61'd0, STAT_AOK});

        // Halt on 3rd instruction, then frozen despite start pulses
        do_reset();
        do_start();
        run_instr(64'd100);
        run_instr(64'd200);
        hlt = 1'b1;
        new_pc = 64'hdead;
        tick();
        hlt = 1'b0;
        check_val("hlt_status", {61'd0, status}, {61'd0, STAT_HLT});
        check_val("hlt_running", {63'd0, running}, 64'd0);
        check_val("hlt_retired", {32'd0, retired}, 64'd2);
        check_val("hlt_pc", pc, 64'd200);
        seen_en = '0;
        for (int i = 0; i < 20; i++) begin
            start = (i % 3 == 0);
            tick();
            seen_en = seen_en | stage_en;
        end
        start = 1'b0;
        check_val("hlt_frozen_pc", pc, 64'd200);
        check_val("hlt_frozen_status", {61'd0, status}, {61'd0, STAT_HLT});
        check_val("hlt_frozen_en", {58'd0, seen_en}, 64'd0);
        check_val("hlt_frozen_retired", {32'd0, retired}, 64'd2);

        // Fetch fault priority
        fetch_fault(1'b1, 1'b1, 1'b0, STAT_ADR, "mem_inst");
        fetch_fault(1'b0, 1'b1, 1'b0, STAT_INS, "inst");
        fetch_fault(1'b0, 1'b1, 1'b1, STAT_INS, "inst_hlt");
        fetch_fault(1'b1, 1'b0, 1'b1, STAT_ADR, "mem_hlt");

        // Data memory fault in MEM
        do_reset();
        do_start();
        run_instr(64'd50);
        new_pc = 64'd999;
        tick();
        tick();
        tick();
        check_val("dmem_in_mem", {58'd0, stage_en}, 64'd1 << EN_MEM);
        dmem_err = 1'b1;
        tick();
        dmem_err = 1'b0;
        check_val("dmem_status", {61'd0, status}, {61'd0, STAT_ADR});
        check_val("dmem_running", {63'd0, running}, 64'd0);
        seen_en = '0;
        for (int i = 0; i < 5; i++) begin
            seen_en = seen_en | stage_en;
            tick();
        end
        check_val("dmem_no_wb_pcupd", {58'd0, seen_en}, 64'd0);
        check_val("dmem_retired", {32'd0, retired}, 64'd1);
        check_val("dmem_pc", pc, 64'd50);

        // Single-step mode
        do_reset();
        step_mode = 1'b1;
        do_start();
        run_instr(64'd77);
        check_val("step_ack_first", {63'd0, step_ack}, 64'd1);
        check_val("step_pause_en", {58'd0, stage_en}, 64'd0);
        tick();
        check_val("step_ack_once", {63'd0, step_ack}, 64'd0);
        seen_en = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen_en = seen_en | stage_en;
        end
        check_val("step_idle_en", {58'd0, seen_en}, 64'd0);
        check_val("step_cycle_hold", {32'd0, cycle_cnt}, 64'd6);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        run_instr(64'd88);
        check_val("step2_ack", {63'd0, step_ack}, 64'd1);
        check_val("step2_cycles", {32'd0, cycle_cnt}, 64'd12);
        tick();
        check_val("step2_paused", {58'd0, stage_en}, 64'd0);
        step_req = 1'b1;
        step_mode = 1'b0;
        tick();
        step_req = 1'b0;
        run_instr(64'd99);
        check_val("freerun_fetch", {58'd0, stage_en}, 64'd1 << EN_FETCH);
        check_val("freerun_no_ack", {63'd0, step_ack}, 64'd0);

        // Reset in EXEC, start coinciding with reset is lost
        do_reset();
        do_start();
        run_instr(64'd60);
        new_pc = 64'd777;
        tick();
        tick();
        check_val("rst_mid_exec", {58'd0, stage_en}, 64'd1 << EN_EXEC);
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check_val("rst_mid_pc", pc, RST_PC);
        check_val("rst_mid_status", {61'd0, status}, {61'd0, STAT_AOK});
        check_val("rst_mid_cycles", {32'd0, cycle_cnt}, 64'd0);
        check_val("rst_mid_retired", {32'd0, retired}, 64'd0);
        check_val("rst_mid_en", {58'd0, stage_en}, 64'd0);
        tick();
        check_val("rst_start_lost", {58'd0, stage_en}, 64'd0);
        m_ret = 0;
        do_start();
        run_instr(64'd5);
        check_val("rerun_cycles", {32'd0, cycle_cnt}, 64'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_controller.md
# seq_controller

Multi-cycle sequencer for the Y86-64 sequential datapath. It owns the architectural PC and the status register (AOK/HLT/ADR/INS). It steps the six stage blocks (fetch, decode, execute, memory, writeback, pc_update) one stage per clock through one-hot enables, and stops the machine on halt or on an exception. It also supports free-run and single-step modes for the bench/debug host, and keeps cycle and retired-instruction counters.

## Interface

Parameters:
- RESET_PC, 64'd0, PC value loaded on reset and on start.
- CNT_W, 32, width of the cycle and retire counters.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse in IDLE begins execution at RESET_PC.
- step_mode  in  1  1 = pause after each retired instruction.
- step_req  in  1  pulse in PAUSE runs exactly one more instruction.
- new_pc  in  64  next-PC value from pc_update.
- hlt  in  1  fetch decoded halt.
- in_mem  in  1  fetch address invalid.
- in_inst  in  1  fetch opcode invalid.
- dmem_err  in  1  memory-stage address invalid.
- pc  out  64  architectural PC presented to fetch.
- stage_en  out  6  one-hot enable; bit0 fetch … bit5 pc_update.
- status  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- running  out  1  high in any stage state.
- step_ack  out  1  one-cycle pulse when an instruction retires in step mode.
- cycle_cnt  out  CNT_W  clock cycles spent in stage states.
- retired  out  CNT_W  instructions completed through PCUPD.

## Operation

- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD, PAUSE, STOP.
- Reset: state=IDLE, pc=RESET_PC, status=AOK, stage_en=0, running=0, step_ack=0, counters=0.
- IDLE: on start, clear counters, set pc=RESET_PC and status=AOK, then go to FETCH. Other inputs are ignored.
- stage_en is a combinational decode of the state: FETCH→000001 … PCUPD→100000. It is 0 in IDLE, PAUSE and STOP.
- FETCH exit: exception priority is in_mem > in_inst > hlt.
  - in_mem → status=ADR, STOP.
  - in_inst → status=INS, STOP.
  - hlt → status=HLT, STOP.
  - None of these → DECODE.
- DECODE→EXEC→MEM unconditionally.
- MEM exit: dmem_err → status=ADR, STOP. WB and PCUPD are not entered, so no register write and no PC change. Otherwise go to WB.
- WB→PCUPD.
- PCUPD: pc<=new_pc and retired+1. If step_mode=1, go to PAUSE and pulse step_ack. Otherwise go to FETCH.
- PAUSE: step_req → FETCH. If step_mode is cleared, resume FETCH the next cycle.
- STOP: terminal. Only rst leaves it. pc and status stay frozen; start is ignored.
- Halted and faulting instructions do not increment retired.
- cycle_cnt increments once for every cycle spent in FETCH..PCUPD. Both counters wrap modulo 2^CNT_W.

## Timing

- A normal instruction takes 6 cycles: FETCH at cycle n, PCUPD at n+5, next FETCH at n+6.
- start sampled at edge k → FETCH active in cycle k+1.
- The new pc is visible the cycle after PCUPD, i.e. in the same cycle as the next FETCH.
- status changes on the edge that leaves FETCH or MEM. running drops in that same cycle.
- step_ack is high during the first PAUSE cycle only.
- If step_req and step_mode=0 are both true in PAUSE, the result is a single transition to FETCH.
- rst overrides everything, including a mid-instruction state: the next cycle is IDLE with all reset values and no partial PC update.
- A start that coincides with rst is lost.

## Structure

- Shared package seq_pkg holds:
  - the status constants STAT_AOK=3'd1, STAT_HLT=3'd2, STAT_ADR=3'd3, STAT_INS=3'd4;
  - the state enum;
  - the stage_en bit indices.
- The existing testbench status logic must use seq_pkg instead of literals.
- Sub-module seq_perf_cnt holds cycle_cnt and retired (inc/clear inputs, parameter CNT_W). The FSM, pc and status registers stay at the top level.

## Test plan

- Reset, start, then four AOK instructions with new_pc=10,20,30,40 → after 24 cycles pc=40, retired=4, cycle_cnt=24, status=1, and stage_en walks one-hot each cycle.
- hlt asserted in FETCH of the 3rd instruction → status=2 on the next edge, running=0, retired=2, pc unchanged, and pc still frozen after 20 more cycles with start pulses.
- in_mem and in_inst asserted together in FETCH → status=3. in_inst alone → status=4.
- dmem_err asserted in MEM → status=3, STOP, no WB/PCUPD enable seen, retired unchanged.
- step_mode=1 → PAUSE after each PCUPD and step_ack pulses once. With no step_req for 10 cycles, stage_en=0 and cycle_cnt is held. A step_req pulse runs exactly one more instruction.
- rst asserted in EXEC → the next cycle is IDLE, pc=RESET_PC, status=1, counters=0. A following start runs normally.
